clock_tick_counter: RTL and testbench
=====================================

# clock_tick_counter

Consumer end of the 10 Hz time base. Takes the divided square wave produced by the clock divider (one toggle every 100 ms) and converts each transition into a single-cycle enable in the 1 MHz domain. It maintains a BCD time-of-day count (HH:MM:SS plus tenths) and supports a validated time-load. Its outputs feed the display/segment logic of the clock.

## Interface
Parameters:
- TICKS_PER_SEC, default 10: tick_in transitions per second; the tenths counter wraps at TICKS_PER_SEC-1.
- DECI_W, default 4: width of the tenths counter; must satisfy 2^DECI_W >= TICKS_PER_SEC.

Ports:
- clk_in  input  1  system clock, 1 MHz
- res  input  1  synchronous, active-high reset
- ena  input  1  count enable; tick edges seen while low are discarded
- tick_in  input  1  divided square wave; every edge, rising or falling, equals 100 ms
- load  input  1  single-cycle request to load hours/minutes
- load_h_t  input  2  hours tens (BCD)
- load_h_u  input  4  hours units (BCD)
- load_m_t  input  3  minutes tens (BCD)
- load_m_u  input  4  minutes units (BCD)
- hours_t  output  2  hours tens
- hours_u  output  4  hours units
- min_t  output  3  minutes tens
- min_u  output  4  minutes units
- sec_t  output  3  seconds tens
- sec_u  output  4  seconds units
- sec_pulse  output  1  one-cycle pulse on every seconds increment
- load_err  output  1  one-cycle pulse when a load is rejected

## Operation
- Edge detector: prev register holds the last sampled tick value. edge = sampled ^ prev. Both polarities count.
- Tick accepted when edge && ena. Edges arriving while ena=0 are dropped, not queued. prev keeps tracking regardless of ena.
- Counter chain, all carries in one cycle: deci 0..TICKS_PER_SEC-1, sec_u 0..9, sec_t 0..5, min_u 0..9, min_t 0..5, hours 00..23.
- Hours wrap: at 23 with a minutes carry, go to 00. hours_u wraps at 9 when hours_t<2 and at 3 when hours_t=2.
- Full rollover: 23:59:59.(TICKS_PER_SEC-1) plus a tick gives 00:00:00.0, with sec_pulse asserted.
- sec_pulse is high for exactly the cycle in which sec_u/sec_t update.
- Load validity: h_t<=2, h_u<=9, h_u<=3 if h_t=2, m_t<=5, m_u<=9.
- Valid load: hours and minutes take the load values; sec_t, sec_u and deci clear to 0; no sec_pulse.
- Invalid load: all counters unchanged; load_err is high for one cycle; a tick in the same cycle is still applied.
- Valid load coinciding with an accepted tick: the load wins and the tick is discarded.
- ena has no effect on load.

## Timing
- Reset (res high at clk_in edge): all time outputs 0, sec_pulse=0, load_err=0, deci=0.
- During reset, the synchronizer stages and prev load the current tick_in level, so there is no spurious edge after reset release.
- res asserted mid-count: clears on the next edge; it overrides load and tick.
- Latency without sync: a tick_in edge before clock edge N appears on the outputs after edge N+1.
- Latency with sync: +2 cycles, i.e. after edge N+3.
- load is sampled at clock edge N; the outputs or load_err reflect it after edge N.
- Minimum tick_in level time: 4 clk_in cycles. Shorter pulses may be lost.

## Configuration
- CLOCK_TICK_SYNC_EN defined: two-flop synchronizer on tick_in ahead of the edge detector. Use this when tick_in comes from a different clock or a pin.
- CLOCK_TICK_SYNC_EN undefined: tick_in is sampled directly by prev. Only legal when tick_in is driven by a register on clk_in.
- Function is identical in both builds; only latency differs.

## Structure
- Shared package clock_pkg holds:
  - BCD limit constants (SEC_T_MAX=5, MIN_T_MAX=5, HOUR_MAX_T=2, HOUR_MAX_U_AT_2=3)
  - digit width localparams
  - the load validity function
- Sub-module tick_edge_detect holds the optional synchronizer, prev register and edge output. The top holds the counter chain and load logic.

## Test plan
- Reset with tick_in=1, then release: no sec_pulse and all digits 0 after 20 cycles.
- Toggle tick_in 10 times, 10 cycles apart, ena=1: sec_u=1, one sec_pulse; latency 1 cycle, or 3 with the macro.
- Load 23:59, then 600 edges: outputs 00:00:00, with a sec_pulse on the final edge.
- Load 24:00 and 19:60: load_err pulses once each; counters unchanged.
- Valid load in the same cycle as a tick edge: loaded value with seconds 00; the tick is discarded.
- ena=0 across 5 edges, then ena=1 across 5 edges: deci=5, no backlog; res mid-count clears everything next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Purpose: shared BCD limits, digit widths and load validation for the time-of-day counter.
// Latency: n/a (constants and a pure combinational function).
// Backpressure: n/a.
package clock_pkg;

    // Digit widths of the HH:MM:SS BCD fields.
    localparam int H_T_W = 2;
    localparam int H_U_W = 4;
    localparam int M_T_W = 3;
    localparam int M_U_W = 4;
    localparam int S_T_W = 3;
    localparam int S_U_W = 4;

    // BCD limit constants.
    localparam logic [S_T_W-1:0] SEC_T_MAX       = 3'd5;
    localparam logic [M_T_W-1:0] MIN_T_MAX       = 3'd5;
    localparam logic [H_T_W-1:0] HOUR_MAX_T      = 2'd2;
    localparam logic [H_U_W-1:0] HOUR_MAX_U_AT_2 = 4'd3;
    localparam logic [3:0]       BCD_NINE        = 4'd9;

    // True when the requested HH:MM is a legal 24-hour time.
    function automatic logic load_valid(
        input logic [H_T_W-1:0] h_t,
        input logic [H_U_W-1:0] h_u,
        input logic [M_T_W-1:0] m_t,
        input logic [M_U_W-1:0] m_u
    );
        logic ok;
        ok = (h_t <= HOUR_MAX_T) && (h_u <= BCD_NINE) &&
             (m_t <= MIN_T_MAX) && (m_u <= BCD_NINE);
        if ((h_t == HOUR_MAX_T) && (h_u > HOUR_MAX_U_AT_2)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Purpose: detect both edges of tick_in; optional 2-flop synchronizer when CLOCK_TICK_SYNC_EN is defined.
// Latency: tick_edge is high the cycle after the sampling edge (+2 cycles with CLOCK_TICK_SYNC_EN).
// Backpressure: none; produces a one-cycle level per tick_in transition.
module tick_edge_detect (
    input  logic clk_in,
    input  logic res,
    input  logic tick_in,
    output logic tick_edge
);

    logic stage_in;
    logic sampled;
    logic prev;

`ifdef CLOCK_TICK_SYNC_EN
    logic sync_a;
    logic sync_b;

    // Two-flop synchronizer; reset preloads the current level so release makes no edge.
    always_ff @(posedge clk_in) begin
        if (res) begin
            sync_a <= tick_in;
            sync_b <= tick_in;
        end else begin
            sync_a <= tick_in;
            sync_b <= sync_a;
        end
    end

    assign stage_in = sync_b;
`else
    assign stage_in = tick_in;
`endif

    // Sample register and previous-value register forming the edge detector.
    always_ff @(posedge clk_in) begin
        if (res) begin
            sampled <= tick_in;
            prev    <= tick_in;
        end else begin
            sampled <= stage_in;
            prev    <= sampled;
        end
    end

    assign tick_edge = sampled ^ prev;

endmodule

// File: rtl/clock_tick_counter.sv
// Purpose: turn tick_in transitions into tenths ticks and keep a BCD HH:MM:SS time with validated load.
// Latency: tick_in edge before clk edge N shows after edge N+1 (N+3 with CLOCK_TICK_SYNC_EN); load shows after its edge.
// Backpressure: none; edges arriving while ena is low are dropped, never queued.
module clock_tick_counter
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10,
    parameter int DECI_W        = 4
) (
    input  logic             clk_in,
    input  logic             res,
    input  logic             ena,
    input  logic             tick_in,
    input  logic             load,
    input  logic [H_T_W-1:0] load_h_t,
    input  logic [H_U_W-1:0] load_h_u,
    input  logic [M_T_W-1:0] load_m_t,
    input  logic [M_U_W-1:0] load_m_u,
    output logic [H_T_W-1:0] hours_t,
    output logic [H_U_W-1:0] hours_u,
    output logic [M_T_W-1:0] min_t,
    output logic [M_U_W-1:0] min_u,
    output logic [S_T_W-1:0] sec_t,
    output logic [S_U_W-1:0] sec_u,
    output logic             sec_pulse,
    output logic             load_err
);

    localparam logic [DECI_W-1:0] DECI_LAST = DECI_W'(TICKS_PER_SEC - 1);

    logic              tick_edge;
    logic              tick;
    logic              load_ok;
    logic [DECI_W-1:0] deci;

    logic              deci_wrap, su_wrap, st_wrap, mu_wrap, mt_wrap;
    logic              hour_last;

    logic [H_T_W-1:0]  nxt_hours_t;
    logic [H_U_W-1:0]  nxt_hours_u;
    logic [M_T_W-1:0]  nxt_min_t;
    logic [M_U_W-1:0]  nxt_min_u;
    logic [S_T_W-1:0]  nxt_sec_t;
    logic [S_U_W-1:0]  nxt_sec_u;
    logic [DECI_W-1:0] nxt_deci;
    logic              nxt_sec_pulse;
    logic              nxt_load_err;

    tick_edge_detect u_edge (
        .clk_in    (clk_in),
        .res       (res),
        .tick_in   (tick_in),
        .tick_edge (tick_edge)
    );

    assign tick    = tick_edge && ena;
    assign load_ok = load_valid(load_h_t, load_h_u, load_m_t, load_m_u);

    // Ripple carries across all digits so a full rollover settles in one cycle.
    assign deci_wrap = tick && (deci == DECI_LAST);
    assign su_wrap   = deci_wrap && (sec_u == BCD_NINE);
    assign st_wrap   = su_wrap && (sec_t == SEC_T_MAX);
    assign mu_wrap   = st_wrap && (min_u == BCD_NINE);
    assign mt_wrap   = mu_wrap && (min_t == MIN_T_MAX);
    assign hour_last = (hours_t == HOUR_MAX_T) && (hours_u == HOUR_MAX_U_AT_2);

    // Next-state: a valid load beats a tick; an invalid load flags an error but lets the tick through.
    always_comb begin
        nxt_hours_t   = hours_t;
        nxt_hours_u   = hours_u;
        nxt_min_t     = min_t;
        nxt_min_u     = min_u;
        nxt_sec_t     = sec_t;
        nxt_sec_u     = sec_u;
        nxt_deci      = deci;
        nxt_sec_pulse = 1'b0;
        nxt_load_err  = 1'b0;

        if (load && load_ok) begin
            nxt_hours_t = load_h_t;
            nxt_hours_u = load_h_u;
            nxt_min_t   = load_m_t;
            nxt_min_u   = load_m_u;
            nxt_sec_t   = '0;
            nxt_sec_u   = '0;
            nxt_deci    = '0;
        end else begin
            nxt_load_err = load;
            if (tick) begin
                nxt_deci = deci_wrap ? '0 : deci + 1'b1;
            end
            if (deci_wrap) begin
                nxt_sec_u     = su_wrap ? '0 : sec_u + 1'b1;
                nxt_sec_pulse = 1'b1;
            end
            if (su_wrap) begin
                nxt_sec_t = st_wrap ? '0 : sec_t + 1'b1;
            end
            if (st_wrap) begin
                nxt_min_u = mu_wrap ? '0 : min_u + 1'b1;
            end
            if (mu_wrap) begin
                nxt_min_t = mt_wrap ? '0 : min_t + 1'b1;
            end
            if (mt_wrap) begin
                if (hour_last) begin
                    nxt_hours_t = '0;
                    nxt_hours_u = '0;
                end else if (hours_u == BCD_NINE) begin
                    nxt_hours_t = hours_t + 1'b1;
                    nxt_hours_u = '0;
                end else begin
                    nxt_hours_u = hours_u + 1'b1;
                end
            end
        end
    end

    // Time registers and one-cycle status pulses; reset overrides load and tick.
    always_ff @(posedge clk_in) begin
        if (res) begin
            hours_t   <= '0;
            hours_u   <= '0;
            min_t     <= '0;
            min_u     <= '0;
            sec_t     <= '0;
            sec_u     <= '0;
            deci      <= '0;
            sec_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            hours_t   <= nxt_hours_t;
            hours_u   <= nxt_hours_u;
            min_t     <= nxt_min_t;
            min_u     <= nxt_min_u;
            sec_t     <= nxt_sec_t;
            sec_u     <= nxt_sec_u;
            deci      <= nxt_deci;
            sec_pulse <= nxt_sec_pulse;
            load_err  <= nxt_load_err;
        end
    end

endmodule

// File: tb/tb_clock_tick_counter.sv
// Purpose: scoreboard bench for clock_tick_counter against an integer time-of-day model.
// Latency: expects tick edges after 2 clocks (4 with CLOCK_TICK_SYNC_EN) and loads after 1.
// Backpressure: n/a.
module tb_clock_tick_counter;

`ifdef CLOCK_TICK_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk_in = 1'b0;
    logic       res = 1'b1;
    logic       ena = 1'b1;
    logic       tick_in = 1'b1;
    logic       load = 1'b0;
    logic [1:0] load_h_t = '0;
    logic [3:0] load_h_u = '0;
    logic [2:0] load_m_t = '0;
    logic [3:0] load_m_u = '0;
    logic [1:0] hours_t;
    logic [3:0] hours_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
    logic       sec_pulse;
    logic       load_err;

    clock_tick_counter dut (
        .clk_in    (clk_in),
        .res       (res),
        .ena       (ena),
        .tick_in   (tick_in),
        .load      (load),
        .load_h_t  (load_h_t),
        .load_h_u  (load_h_u),
        .load_m_t  (load_m_t),
        .load_m_u  (load_m_u),
        .hours_t   (hours_t),
        .hours_u   (hours_u),
        .min_t     (min_t),
        .min_u     (min_u),
        .sec_t     (sec_t),
        .sec_u     (sec_u),
        .sec_pulse (sec_pulse),
        .load_err  (load_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [19:0] dig;
        logic        pulse;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    int   base;
    int   mh, mm, ms, md;

    always @(negedge clk_in) if (sec_pulse) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pack(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [19:0] dut_dig();
        return {hours_t, hours_u, min_t, min_u, sec_t, sec_u};
    endfunction

    task automatic model_tick(output logic p);
        p = 1'b0;
        md++;
        if (md == 10) begin
            md = 0;
            p  = 1'b1;
            ms++;
            if (ms == 60) begin
                ms = 0;
                mm++;
                if (mm == 60) begin
                    mm = 0;
                    mh = (mh == 23) ? 0 : mh + 1;
                end
            end
        end
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, "_dig"}, 32'(dut_dig()), 32'(e.dig));
        check({tag, "_pulse"}, 32'(sec_pulse), 32'(e.pulse));
        check({tag, "_err"}, 32'(load_err), 32'(e.err));
    endtask

    // One tick_in transition, checked at the exact cycle the counters must update.
    task automatic do_edge(input string tag);
        exp_t e;
        logic p;
        @(negedge clk_in);
        tick_in = ~tick_in;
        p = 1'b0;
        if (ena) model_tick(p);
        e.dig = pack(mh, mm, ms); e.pulse = p; e.err = 1'b0;
        sb.push_back(e);
        repeat (LAT) @(posedge clk_in);
        #1;
        pop_and_check(tag);
        repeat (6) @(posedge clk_in);
    endtask

    // Load request, optionally timed so a tick edge reaches the counters in the same cycle.
    task automatic do_load(input int ht, input int hu, input int mt, input int mu,
                           input bit with_tick, input string tag);
        exp_t e;
        logic p;
        bit   ok;
        if (with_tick) begin
            @(negedge clk_in);
            tick_in = ~tick_in;
            repeat (LAT - 1) @(negedge clk_in);
        end else begin
            @(negedge clk_in);
        end
        load = 1'b1;
        load_h_t = 2'(ht); load_h_u = 4'(hu); load_m_t = 3'(mt); load_m_u = 4'(mu);
        ok = (ht * 10 + hu < 24) && (hu <= 9) && (mt <= 5) && (mu <= 9);
        p = 1'b0;
        if (ok) begin
            mh = ht * 10 + hu; mm = mt * 10 + mu; ms = 0; md = 0;
        end else if (with_tick && ena) begin
            model_tick(p);
        end
        e.dig = pack(mh, mm, ms); e.pulse = p; e.err = !ok;
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        pop_and_check(tag);
        @(negedge clk_in);
        load = 1'b0;
        @(posedge clk_in);
        #1;
        check({tag, "_err_clear"}, 32'(load_err), 32'd0);
        repeat (4) @(posedge clk_in);
    endtask

    initial begin
        mh = 0; mm = 0; ms = 0; md = 0;

        // Reset with tick_in high, then release: no spurious edge.
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        res = 1'b0;
        repeat (20) @(posedge clk_in);
        #1;
        check("rst_dig", 32'(dut_dig()), 32'(pack(0, 0, 0)));
        check("rst_pulse_cnt", pulse_cnt, 0);
        check("rst_err", 32'(load_err), 32'd0);

        // Ten edges make one second.
        base = pulse_cnt;
        for (int i = 0; i < 10; i++) do_edge("ten");
        check("ten_dig", 32'(dut_dig()), 32'(pack(0, 0, 1)));
        check("ten_pulses", pulse_cnt - base, 1);

        // Full rollover from 23:59.
        do_load(2, 3, 5, 9, 1'b0, "ld2359");
        base = pulse_cnt;
        for (int i = 0; i < 600; i++) do_edge("roll");
        check("roll_dig", 32'(dut_dig()), 32'(pack(0, 0, 0)));
        check("roll_pulses", pulse_cnt - base, 60);

        // Invalid loads leave the counters alone.
        do_edge("pre_bad");
        do_load(2, 4, 0, 0, 1'b0, "bad2400");
        do_load(1, 9, 6, 0, 1'b0, "bad1960");
        do_load(2, 4, 0, 0, 1'b1, "bad_tick");

        // Valid load with a coincident tick: tick discarded, then a full second needs 10 edges.
        do_load(1, 2, 3, 4, 1'b1, "ld_tick");
        base = pulse_cnt;
        for (int i = 0; i < 9; i++) do_edge("after_ld");
        check("after_ld_pulses", pulse_cnt - base, 0);
        do_edge("after_ld10");
        check("after_ld10_dig", 32'(dut_dig()), 32'(pack(12, 34, 1)));

        // Edges during ena low are dropped, not queued.
        base = pulse_cnt;
        ena = 1'b0;
        for (int i = 0; i < 5; i++) do_edge("ena_off");
        ena = 1'b1;
        for (int i = 0; i < 5; i++) do_edge("ena_on");
        check("ena_pulses", pulse_cnt - base, 0);
        for (int i = 0; i < 5; i++) do_edge("ena_more");
        check("ena_more_pulses", pulse_cnt - base, 1);
        check("ena_dig", 32'(dut_dig()), 32'(pack(12, 34, 2)));

        // Mid-count reset overrides a concurrent valid load.
        do_edge("pre_rst");
        @(negedge clk_in);
        res = 1'b1;
        load = 1'b1; load_h_t = 2'd1; load_h_u = 4'd5; load_m_t = 3'd0; load_m_u = 4'd0;
        @(posedge clk_in);
        #1;
        check("midrst_dig", 32'(dut_dig()), 32'(pack(0, 0, 0)));
        check("midrst_pulse", 32'(sec_pulse), 32'd0);
        check("midrst_err", 32'(load_err), 32'd0);
        @(negedge clk_in);
        res = 1'b0;
        load = 1'b0;
        mh = 0; mm = 0; ms = 0; md = 0;
        repeat (4) @(posedge clk_in);
        for (int i = 0; i < 10; i++) do_edge("post_rst");
        check("post_rst_dig", 32'(dut_dig()), 32'(pack(0, 0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
